// File: rtl/ascii_operand_loader_if.sv
// Bundles the keyboard byte channel and the operand hand-off towards the adder.
// The master side is the environment: it drives bytes and consumes operand sets.
// The slave side is the loader itself.
interface ascii_operand_loader_if #(
  parameter int WIDTH = 5
);
  // Keyboard byte channel
  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;

  // Operand set towards the adder stage
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c0;

  // Malformed-sequence indication
  logic             bad_input;

  modport master (
    output char_valid, char_data, op_ready,
    input  char_ready, op_valid, x, y, c0, bad_input
  );

  modport slave (
    input  char_valid, char_data, op_ready,
    output char_ready, op_valid, x, y, c0, bad_input
  );
endinterface

// File: rtl/ascii_operand_loader.sv
// Parses "DD<Enter>DD<Enter><op>" from a keyboard byte stream into operands
// x, y and the add/subtract bit c0, then offers them to the adder via valid/ready.
// Any byte that breaks the grammar discards the partial set and pulses bad_input.
module ascii_operand_loader #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ascii_operand_loader_if.slave bus
);

  localparam logic [6:0] MAX_V = 7'(MAX_VAL);

  typedef enum logic [2:0] {
    X_D1,
    X_D2,
    X_ENT,
    Y_D1,
    Y_D2,
    Y_ENT,
    OP,
    HOLD
  } state_t;

  state_t           state;
  logic [3:0]       tens;
  logic [WIDTH-1:0] x_acc;
  logic [WIDTH-1:0] y_acc;

  logic             accept;
  logic             is_digit;
  logic             is_enter;
  logic             is_plus;
  logic             is_minus;
  logic [3:0]       digit;
  logic [6:0]       value;
  logic             value_ok;
  logic             byte_ok;

  // Bytes are refused only while a finished set waits for the adder.
  assign bus.char_ready = (state != HOLD);
  assign accept         = bus.char_valid && bus.char_ready;

  // Character classes; for '0'..'9' the low nibble is the digit value.
  assign is_digit = (bus.char_data >= 8'h30) && (bus.char_data <= 8'h39);
  assign is_enter = (bus.char_data == 8'h0A) || (bus.char_data == 8'h0D);
  assign is_plus  = (bus.char_data == 8'h2B);
  assign is_minus = (bus.char_data == 8'h2D);
  assign digit    = bus.char_data[3:0];

  // Two-digit decimal value; 7 bits cover 0..99.
  assign value    = ({3'b000, tens} * 7'd10) + {3'b000, digit};
  assign value_ok = is_digit && (value <= MAX_V);

  // Decide whether the current byte is legal in the current state.
  always_comb begin
    // NOTE: default first so every path assigns byte_ok and no latch is inferred.
    byte_ok = 1'b0;
    case (state)
      X_D1, Y_D1:   byte_ok = is_digit;
      X_D2, Y_D2:   byte_ok = value_ok;
      X_ENT, Y_ENT: byte_ok = is_enter;
      OP:           byte_ok = is_plus || is_minus;
      default:      byte_ok = 1'b0;
    endcase
  end

  // Parser FSM with registered operand outputs and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= X_D1;
      tens          <= '0;
      x_acc         <= '0;
      y_acc         <= '0;
      bus.x         <= '0;
      bus.y         <= '0;
      bus.c0        <= 1'b0;
      bus.op_valid  <= 1'b0;
      bus.bad_input <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      bus.bad_input <= 1'b0;

      if (state == HOLD) begin
        // Offered set stays frozen until the adder takes it.
        if (bus.op_ready) begin
          bus.op_valid <= 1'b0;
          state        <= X_D1;
        end
      end else if (accept && !byte_ok) begin
        // Malformed byte: drop the partial set, keep the last delivered outputs.
        bus.bad_input <= 1'b1;
        state         <= X_D1;
      end else if (accept) begin
        case (state)
          X_D1: begin
            tens  <= digit;
            state <= X_D2;
          end
          X_D2: begin
            x_acc <= value[WIDTH-1:0];
            state <= X_ENT;
          end
          X_ENT: begin
            state <= Y_D1;
          end
          Y_D1: begin
            tens  <= digit;
            state <= Y_D2;
          end
          Y_D2: begin
            y_acc <= value[WIDTH-1:0];
            state <= Y_ENT;
          end
          Y_ENT: begin
            state <= OP;
          end
          OP: begin
            // Commit the staged operands only once the whole sequence is valid.
            bus.x        <= x_acc;
            bus.y        <= y_acc;
            bus.c0       <= is_minus;
            bus.op_valid <= 1'b1;
            state        <= HOLD;
          end
          default: begin
            state <= X_D1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_operand_loader.sv
// Self-checking bench for ascii_operand_loader: a sequence-level parser model
// predicts operand sets and error pulses; a monitor compares DUT outputs.
module tb_ascii_operand_loader;

  localparam int WIDTH   = 5;
  localparam int MAX_VAL = 15;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c0;
  } opset_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ascii_operand_loader_if #(.WIDTH(WIDTH)) bus ();

  ascii_operand_loader #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  opset_t       op_q[$];
  byte unsigned pending[$];
  bit           bad_exp     = 1'b0;
  opset_t       last        = '0;
  bit           seen        = 1'b0;
  bit           hs_prev     = 1'b0;
  int           delivered   = 0;
  bit           block_ready = 1'b1;
  bit           rand_ready  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_dig(input byte unsigned b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic int dval(input byte unsigned b);
    return int'(b) - 48;
  endfunction

  // Reference model: the attempt so far must be a prefix of DD<Enter>DD<Enter><op>
  // with each two-digit number no larger than MAX_VAL.
  task automatic model_accept(input byte unsigned b);
    int n;
    bit ok;
    opset_t s;
    pending.push_back(b);
    n  = pending.size();
    ok = 1'b0;
    case (n)
      1, 2, 4, 5: ok = is_dig(b);
      3, 6:       ok = (b == 8'h0A) || (b == 8'h0D);
      7:          ok = (b == 8'h2B) || (b == 8'h2D);
      default:    ok = 1'b0;
    endcase
    if (ok && (n == 2 || n == 5))
      ok = (dval(pending[n-2]) * 10 + dval(b)) <= MAX_VAL;
    if (!ok) begin
      bad_exp = 1'b1;
      pending.delete();
    end else if (n == 7) begin
      s.x  = WIDTH'(dval(pending[0]) * 10 + dval(pending[1]));
      s.y  = WIDTH'(dval(pending[3]) * 10 + dval(pending[4]));
      s.c0 = (b == 8'h2D);
      op_q.push_back(s);
      pending.delete();
    end
  endtask

  task automatic model_reset();
    pending.delete();
    op_q.delete();
    bad_exp = 1'b0;
    last    = '0;
    seen    = 1'b0;
    hs_prev = 1'b0;
  endtask

  // Present one byte after an idle gap; called at posedge+1, returns at posedge+1.
  task automatic send_byte(input byte unsigned b, input int gap);
    int waited;
    repeat (gap) begin
      bus.char_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.char_ready) begin
        @(posedge clk); #1;
        model_accept(b);
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 300) begin
        check("char_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.char_valid = 1'b0;
  endtask

  task automatic send_seq(input byte unsigned seq[$], input int gap_max);
    foreach (seq[i]) send_byte(seq[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic send_str(input string s, input int gap_max);
    byte unsigned q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_seq(q, gap_max);
  endtask

  // Wait until every predicted set has been delivered and taken.
  task automatic drain();
    int n;
    n = 0;
    while ((op_q.size() != 0 || bus.op_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(op_q.size()), 32'd0);
    check("drain_op_valid_low", 32'(bus.op_valid), 32'd0);
  endtask

  // Adder-side readiness: blocked, always ready, or random.
  initial begin
    bus.op_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.op_ready = block_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: compares outputs against the scoreboard on every falling edge.
  initial begin
    opset_t s;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("bad_input", 32'(bus.bad_input), 32'(bad_exp));
        bad_exp = 1'b0;
        check("char_ready_vs_hold", 32'(bus.char_ready), 32'(!bus.op_valid));
        if (hs_prev) check("op_valid_drop", 32'(bus.op_valid), 32'd0);
        if (bus.op_valid && !seen) begin
          if (op_q.size() == 0) begin
            check("spurious_op_valid", 32'd1, 32'd0);
          end else begin
            s = op_q.pop_front();
            check("x", 32'(bus.x), 32'(s.x));
            check("y", 32'(bus.y), 32'(s.y));
            check("c0", 32'(bus.c0), 32'(s.c0));
            last = s;
            delivered++;
          end
          seen = 1'b1;
        end else if (bus.op_valid) begin
          check("x_stable", 32'(bus.x), 32'(last.x));
          check("y_stable", 32'(bus.y), 32'(last.y));
          check("c0_stable", 32'(bus.c0), 32'(last.c0));
        end else begin
          seen = 1'b0;
          check("x_idle", 32'(bus.x), 32'(last.x));
          check("y_idle", 32'(bus.y), 32'(last.y));
          check("c0_idle", 32'(bus.c0), 32'(last.c0));
        end
        hs_prev = bus.op_valid && bus.op_ready;
        if (hs_prev) seen = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, 32'(bus.x), 32'd0);
    check({tag, "_y"}, 32'(bus.y), 32'd0);
    check({tag, "_c0"}, 32'(bus.c0), 32'd0);
    check({tag, "_op_valid"}, 32'(bus.op_valid), 32'd0);
    check({tag, "_bad_input"}, 32'(bus.bad_input), 32'd0);
    check({tag, "_char_ready"}, 32'(bus.char_ready), 32'd1);
  endtask

  initial begin
    int base;
    byte unsigned seq[$];
    int xv, yv, p;

    rst_n          = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add set, consumed immediately.
    block_ready = 1'b0;
    send_str("07\01212\012+", 0);
    drain();

    // Subtract set held for ten cycles; a following byte must wait.
    block_ready = 1'b1;
    send_str("15\01503\015-", 0);
    fork
      send_str("16\012", 0);
      begin
        repeat (10) begin
          @(negedge clk);
          check("hold_char_ready", 32'(bus.char_ready), 32'd0);
          check("hold_op_valid", 32'(bus.op_valid), 32'd1);
          check("hold_x", 32'(bus.x), 32'd15);
        end
        @(posedge clk); #1;
        block_ready = 1'b0;
      end
    join
    send_str("02\01201\012+", 0);
    drain();

    // Malformed sequences: each must pulse bad_input and deliver nothing.
    base = delivered;
    send_str("0A", 1);
    send_str("05X", 1);
    send_str("05\01205\012*", 1);
    send_str("/:", 0);
    repeat (3) begin @(posedge clk); #1; end
    check("malformed_no_delivery", 32'(delivered), 32'(base));
    check("malformed_x_kept", 32'(bus.x), 32'd2);
    check("malformed_y_kept", 32'(bus.y), 32'd1);

    // Reset in the middle of a sequence.
    send_str("05\0121", 0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_str("09\01209\012-", 0);
    drain();

    // Back-to-back sets with bytes offered every cycle.
    base = delivered;
    send_str("03\01204\012+11\01510\012-", 0);
    drain();
    check("back_to_back_sets", 32'(delivered), 32'(base + 2));

    // Randomised sets, some out of range, some corrupted, random gaps and readiness.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      xv = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : int'($urandom_range(0, MAX_VAL)));
      yv = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : int'($urandom_range(0, MAX_VAL)));
      seq.delete();
      seq.push_back(8'(48 + xv / 10));
      seq.push_back(8'(48 + xv % 10));
      seq.push_back(($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D);
      seq.push_back(8'(48 + yv / 10));
      seq.push_back(8'(48 + yv % 10));
      seq.push_back(($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D);
      seq.push_back(($urandom_range(0, 1) != 0) ? 8'h2B : 8'h2D);
      if ($urandom_range(0, 3) == 0) begin
        p = int'($urandom_range(0, 6));
        case (p)
          0, 1, 3, 4: seq[p] = ($urandom_range(0, 1) != 0) ? 8'h2F : 8'h3A;
          2, 5:       seq[p] = ($urandom_range(0, 1) != 0) ? 8'h0B : 8'h35;
          default:    seq[p] = ($urandom_range(0, 1) != 0) ? 8'h2A : 8'h3D;
        endcase
        while (seq.size() > p + 1) void'(seq.pop_back());
      end
      send_seq(seq, 2);
    end
    rand_ready = 1'b0;
    drain();
    repeat (2) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
